run_seq_detector: RTL and testbench
===================================

// Module: run_seq_detector
// PURPOSE
//   Serial-bit run detector: flags RUN_LEN consecutive identical bits on w.
//   Generalised successor of the lab7 4-bit shift-register FSM:
//   - clocked on clk
//   - parametrised run length
//   - selectable polarity mode
//   - overlapping/non-overlapping detection
//   - saturating detection counter
//   Sits behind switch/button inputs in top; outputs drive ledr and seg displays.
// PARAMETERS
//   RUN_LEN  4  run length to detect; legal range 2..16
//   CNT_W    8  width of det_cnt
//   OVERLAP  1  1: z high every cycle the run stays >= RUN_LEN; 0: z pulses once per RUN_LEN bits
// PORTS
//   clk      in   1                    system clock; all state updates on rising edge
//   rst      in   1                    synchronous reset, active-high
//   en       in   1                    sample enable; 0 clears detector state (not det_cnt)
//   w        in   1                    serial input bit, sampled when en=1
//   mode     in   2                    00 either polarity, 01 ones only, 10 zeros only, 11 detection off
//   clr_cnt  in   1                    synchronous clear of det_cnt
//   z        out  1                    registered detect flag
//   hist     out  RUN_LEN              last RUN_LEN bits; newest in MSB: hist <= {w, hist[RUN_LEN-1:1]}
//   run_cnt  out  $clog2(RUN_LEN+1)    current run length, saturating at RUN_LEN
//   run_bit  out  1                    polarity of the current run
//   det_cnt  out  CNT_W                number of z-high cycles, saturating at all-ones
// BEHAVIOUR
//   Reset and priority
//   - rst=1: z, hist, run_cnt, run_bit, det_cnt all cleared to 0 next edge.
//   - Priority: rst > en=0 clear > normal sampling.
//   en=0 (no rst)
//   - hist, run_cnt, run_bit and z go to 0 next edge.
//   - det_cnt holds, except that clr_cnt still applies.
//   Run counter (en=1)
//   - run_cnt==0 means no previous bit: run_cnt<=1, run_bit<=w.
//   - w==run_bit: run_cnt <= min(run_cnt+1, RUN_LEN).
//   - w!=run_bit: run_cnt<=1, run_bit<=w.
//   Detection (en=1)
//   - hit = next run_cnt==RUN_LEN, qualified by mode on polarity w:
//     00 any polarity; 01 w=1; 10 w=0; 11 never.
//   - z <= hit. z is registered: it rises on the edge that samples the RUN_LEN-th equal bit.
//   - With en=0 and no rst, z goes to 0 on the next edge.
//   Overlap
//   - OVERLAP=1: z stays 1 each cycle while the run continues.
//   - OVERLAP=0: on hit, run_cnt is loaded with 0 (run_bit keeps w).
//     The next equal bit therefore counts as 1, and z pulses once per RUN_LEN equal bits.
//   Mode changes
//   - mode is sampled combinationally each edge; changing it does not clear the run.
//   det_cnt
//   - Increments on every edge where z is loaded with 1; saturates at 2^CNT_W-1.
//   - clr_cnt=1 loads det_cnt with 0 and wins over a same-cycle increment.
//   hist
//   - Shifts on every en=1 edge regardless of mode. Reset mid-run clears everything.
//   Latency
//   - 1 cycle from w sample to z/run_cnt/hist update. No combinational input-to-output paths.
// TESTING  (RUN_LEN=4, CNT_W=8 unless stated)
//   1. rst=1 for 2 cycles with w=1,en=1 -> z=0, hist=4'b0000, run_cnt=0, det_cnt=0.
//   2. mode=00, OVERLAP=1, en=1, w=1 x6
//      -> z=1 after edges 4,5,6; hist=4'b1111; run_cnt=4; det_cnt=3.
//   3. mode=01, w=0 x5 -> z never 1; then w=1 x4 -> z=1 after 4th one; run_bit=1.
//   4. OVERLAP=0, mode=00, w=0 x8 -> z pulses after edges 4 and 8 only; det_cnt=2.
//   5. w=1,1,1 then en=0 for one cycle, then w=1 -> run_cnt=1, z=0 (run broken).
//      Separately: clr_cnt=1 on a hit edge -> det_cnt=0, z=1.
//   6. CNT_W=2, mode=00, OVERLAP=1, w=1 x10 -> det_cnt saturates at 3;
//      rst mid-run -> all outputs 0 next edge.

Source files
------------

// File: rtl/run_seq_detector_if.sv
// Bus bundle for run_seq_detector: sampling controls in, detector status out.
// master drives controls and observes status; slave is the detector itself.
interface run_seq_detector_if #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned RC_W = $clog2(RUN_LEN + 1);

  logic               en;
  logic               w;
  logic [1:0]         mode;
  logic               clr_cnt;
  logic               z;
  logic [RUN_LEN-1:0] hist;
  logic [RC_W-1:0]    run_cnt;
  logic               run_bit;
  logic [CNT_W-1:0]   det_cnt;

  modport master (
    output en, w, mode, clr_cnt,
    input  z, hist, run_cnt, run_bit, det_cnt
  );

  modport slave (
    input  en, w, mode, clr_cnt,
    output z, hist, run_cnt, run_bit, det_cnt
  );
endinterface

// File: rtl/run_seq_detector.sv
// Serial-bit run detector: flags RUN_LEN consecutive identical bits on w,
// with polarity selection, optional non-overlapping detection and a
// saturating count of detect cycles. All outputs are registered.
module run_seq_detector #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned OVERLAP = 1
) (
  input  logic                clk,
  input  logic                rst,
  run_seq_detector_if.slave   bus
);

  localparam int unsigned     RC_W        = $clog2(RUN_LEN + 1);
  localparam logic [RC_W-1:0] RUN_CNT_MAX = RC_W'(RUN_LEN);
  localparam logic [RC_W-1:0] RUN_CNT_ONE = RC_W'(1);

  typedef enum logic [1:0] {
    MODE_ANY   = 2'b00,
    MODE_ONES  = 2'b01,
    MODE_ZEROS = 2'b10,
    MODE_OFF   = 2'b11
  } mode_e;

  logic               z_q, z_d;
  logic [RUN_LEN-1:0] hist_q, hist_d;
  logic [RC_W-1:0]    run_cnt_q, run_cnt_d;
  logic               run_bit_q, run_bit_d;
  logic [CNT_W-1:0]   det_cnt_q, det_cnt_d;

  logic [RC_W-1:0]    run_next;
  logic               pol_ok;
  logic               hit;
  mode_e              mode_s;

  assign mode_s = mode_e'(bus.mode);

  // Next-state: run tracking, polarity-qualified detection, detect counter
  always_comb begin
    hist_d    = hist_q;
    run_cnt_d = run_cnt_q;
    run_bit_d = run_bit_q;
    z_d       = 1'b0;
    det_cnt_d = det_cnt_q;
    run_next  = '0;
    pol_ok    = 1'b0;
    hit       = 1'b0;

    if (!bus.en) begin
      hist_d    = '0;
      run_cnt_d = '0;
      run_bit_d = 1'b0;
    end else begin
      hist_d = {bus.w, hist_q[RUN_LEN-1:1]};

      // run_cnt==0 means no valid previous bit, so any w starts a fresh run
      if ((run_cnt_q == '0) || (bus.w != run_bit_q)) begin
        run_next = RUN_CNT_ONE;
      end else if (run_cnt_q == RUN_CNT_MAX) begin
        run_next = RUN_CNT_MAX;
      end else begin
        run_next = run_cnt_q + 1'b1;
      end

      case (mode_s)
        MODE_ANY:   pol_ok = 1'b1;
        MODE_ONES:  pol_ok = bus.w;
        MODE_ZEROS: pol_ok = ~bus.w;
        default:    pol_ok = 1'b0;
      endcase

      hit       = (run_next == RUN_CNT_MAX) && pol_ok;
      run_bit_d = bus.w;
      // Non-overlapping: restart counting so the next equal bit counts as 1
      run_cnt_d = (hit && (OVERLAP == 0)) ? '0 : run_next;
      z_d       = hit;
    end

    if (bus.clr_cnt) begin
      det_cnt_d = '0;
    end else if (z_d && (det_cnt_q != '1)) begin
      det_cnt_d = det_cnt_q + 1'b1;
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q       <= 1'b0;
      hist_q    <= '0;
      run_cnt_q <= '0;
      run_bit_q <= 1'b0;
      det_cnt_q <= '0;
    end else begin
      z_q       <= z_d;
      hist_q    <= hist_d;
      run_cnt_q <= run_cnt_d;
      run_bit_q <= run_bit_d;
      det_cnt_q <= det_cnt_d;
    end
  end

  assign bus.z       = z_q;
  assign bus.hist    = hist_q;
  assign bus.run_cnt = run_cnt_q;
  assign bus.run_bit = run_bit_q;
  assign bus.det_cnt = det_cnt_q;

endmodule

// File: tb/tb_run_seq_detector.sv
// Bench for run_seq_detector: three instances (overlap/CNT_W=8,
// non-overlap/CNT_W=8, overlap/CNT_W=2) driven by identical stimulus and
// compared every cycle against a run-length reference model.
module tb_run_seq_detector;

  localparam int unsigned RUN_LEN = 4;

  logic clk;
  logic rst;

  int n_checks;
  int n_pass;

  run_seq_detector_if #(.RUN_LEN(RUN_LEN), .CNT_W(8)) if_a ();
  run_seq_detector_if #(.RUN_LEN(RUN_LEN), .CNT_W(8)) if_b ();
  run_seq_detector_if #(.RUN_LEN(RUN_LEN), .CNT_W(2)) if_c ();

  run_seq_detector #(.RUN_LEN(RUN_LEN), .CNT_W(8), .OVERLAP(1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );
  run_seq_detector #(.RUN_LEN(RUN_LEN), .CNT_W(8), .OVERLAP(0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );
  run_seq_detector #(.RUN_LEN(RUN_LEN), .CNT_W(2), .OVERLAP(1)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: seg = equal bits seen since the run last broke
  // (or since the last non-overlapping hit); unbounded integer.
  int       seg  [3];
  bit       mbit [3];
  bit       mz   [3];
  int       mdet [3];
  logic [3:0] mhist;
  int       ov   [3] = '{1, 0, 1};
  int       dmax [3] = '{255, 255, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int exp_run(input int i);
    return (seg[i] > RUN_LEN) ? RUN_LEN : seg[i];
  endfunction

  task automatic model_update(input bit r, input bit e, input bit ww,
                              input bit [1:0] m, input bit c);
    bit ok;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        seg[i] = 0; mbit[i] = 0; mz[i] = 0; mdet[i] = 0;
      end else if (!e) begin
        seg[i] = 0; mbit[i] = 0; mz[i] = 0;
        if (c) mdet[i] = 0;
      end else begin
        if (seg[i] == 0 || ww != mbit[i]) seg[i] = 1;
        else seg[i] = seg[i] + 1;
        mbit[i] = ww;
        ok = (m == 2'd0) || (m == 2'd1 && ww) || (m == 2'd2 && !ww);
        mz[i] = ok && (seg[i] >= RUN_LEN);
        if (mz[i] && ov[i] == 0) seg[i] = 0;
        if (c) mdet[i] = 0;
        else if (mz[i] && mdet[i] < dmax[i]) mdet[i] = mdet[i] + 1;
      end
    end
    if (r || !e) mhist = 4'b0000;
    else mhist = {ww, mhist[3:1]};
  endtask

  task automatic check_all();
    check("A.z",    32'(if_a.z),       32'(mz[0]));
    check("A.hist", 32'(if_a.hist),    32'(mhist));
    check("A.run",  32'(if_a.run_cnt), 32'(exp_run(0)));
    check("A.bit",  32'(if_a.run_bit), 32'(mbit[0]));
    check("A.det",  32'(if_a.det_cnt), 32'(mdet[0]));
    check("B.z",    32'(if_b.z),       32'(mz[1]));
    check("B.hist", 32'(if_b.hist),    32'(mhist));
    check("B.run",  32'(if_b.run_cnt), 32'(exp_run(1)));
    check("B.bit",  32'(if_b.run_bit), 32'(mbit[1]));
    check("B.det",  32'(if_b.det_cnt), 32'(mdet[1]));
    check("C.z",    32'(if_c.z),       32'(mz[2]));
    check("C.run",  32'(if_c.run_cnt), 32'(exp_run(2)));
    check("C.det",  32'(if_c.det_cnt), 32'(mdet[2]));
  endtask

  task automatic step(input bit r, input bit e, input bit ww,
                      input bit [1:0] m, input bit c);
    rst          = r;
    if_a.en      = e;  if_b.en      = e;  if_c.en      = e;
    if_a.w       = ww; if_b.w       = ww; if_c.w       = ww;
    if_a.mode    = m;  if_b.mode    = m;  if_c.mode    = m;
    if_a.clr_cnt = c;  if_b.clr_cnt = c;  if_c.clr_cnt = c;
    @(posedge clk);
    model_update(r, e, ww, m, c);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit       pw;
    bit       ww;
    bit [1:0] md;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    if_a.en = 1'b1; if_b.en = 1'b1; if_c.en = 1'b1;
    if_a.w  = 1'b1; if_b.w  = 1'b1; if_c.w  = 1'b1;
    if_a.mode = 2'b00; if_b.mode = 2'b00; if_c.mode = 2'b00;
    if_a.clr_cnt = 1'b0; if_b.clr_cnt = 1'b0; if_c.clr_cnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seg[i] = 0; mbit[i] = 0; mz[i] = 0; mdet[i] = 0;
    end
    mhist = 4'b0000;

    // reset for two cycles with w=1, en=1
    step(1, 1, 1, 2'b00, 0);
    step(1, 1, 1, 2'b00, 0);
    check("rst.run", 32'(if_a.run_cnt), 32'd0);

    // w=1 x6, either polarity
    for (int k = 0; k < 6; k++) step(0, 1, 1, 2'b00, 0);
    check("ones6.det",  32'(if_a.det_cnt), 32'd3);
    check("ones6.hist", 32'(if_a.hist),    32'hF);
    check("ones6.detB", 32'(if_b.det_cnt), 32'd1);

    // ones-only mode: zeros never detect, then four ones do
    for (int k = 0; k < 5; k++) step(0, 1, 0, 2'b01, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 2'b01, 0);
    check("ones_only.z", 32'(if_a.z), 32'd1);

    // zeros x8, either polarity
    for (int k = 0; k < 8; k++) step(0, 1, 0, 2'b00, 0);

    // run broken by en=0
    for (int k = 0; k < 3; k++) step(0, 1, 1, 2'b00, 0);
    step(0, 0, 1, 2'b00, 0);
    step(0, 1, 1, 2'b00, 0);
    check("brk.run", 32'(if_a.run_cnt), 32'd1);

    // clr_cnt on a hit edge
    step(0, 1, 1, 2'b00, 0);
    step(0, 1, 1, 2'b00, 0);
    step(0, 1, 1, 2'b00, 1);
    check("clrhit.z",   32'(if_a.z),       32'd1);
    check("clrhit.det", 32'(if_a.det_cnt), 32'd0);

    // long run to saturate the 2-bit counter, then reset mid-run
    for (int k = 0; k < 10; k++) step(0, 1, 1, 2'b00, 0);
    check("sat.detC", 32'(if_c.det_cnt), 32'd3);
    step(1, 1, 1, 2'b00, 0);
    step(0, 1, 1, 2'b00, 0);

    // randomized runs with occasional mode, enable, clear and reset events
    pw = 1'b1;
    md = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 5) begin
        md = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      end
      ww = ($urandom_range(0, 99) < 78) ? pw : ~pw;
      pw = ww;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 95),
           ww, md,
           ($urandom_range(0, 99) < 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
